i2c_reg_target: RTL and testbench
=================================

Name: i2c_reg_target

Overview:
- I2C target (slave) that sits on the far end of the SDA/SCL bus driven by the team's I2C master.
- Decodes its 7-bit address, holds a pointer register, and serves a 4-entry temperature-sensor style register file.
- Oversamples the bus on the system clock, with no clock stretching.
- Becomes the synthesizable replacement for the behavioural slave model in the master bench.

Parameters:
- SLAVE_ADDR, 7'h48, target address matched against the first byte [7:1].
- DEFAULT_VAL, 16'h9821, read-only contents of register 3.
- CFG_RST, 8'h00, reset value of the config register (reg 1).
- GEN_RST, 8'h00, reset value of the general register (reg 2).

Ports:
- clk  in  1  system clock; must be at least 8x SCL frequency.
- rst_n  in  1  synchronous active-low reset.
- scl_i  in  1  raw SCL from pad (asynchronous).
- sda_i  in  1  raw SDA from pad (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain).
- temp_data  in  16  live temperature value for reg 0.
- config_reg  out  8  current reg 1.
- general_reg  out  8  current reg 2.
- wr_strobe  out  1  one-cycle pulse when reg 1 or reg 2 is written.
- busy  out  1  high from address match until STOP or mismatch.

Behaviour:
- Reset values: sda_oe=0, busy=0, wr_strobe=0, config_reg=CFG_RST, general_reg=GEN_RST, pointer=8'h00, state=IDLE.
- Reset asserted mid-transfer releases SDA on the same edge.
- Synchronizer: SCL and SDA each pass a 2-FF synchronizer. Rise/fall detect on the synchronized copies.
- START: SDA fall while SCL high. STOP: SDA rise while SCL high.
- Bits are sampled on the synchronized SCL rise. sda_oe changes only on the synchronized SCL fall, one clk after detection.
- A bit counter runs 7..0, MSB first. A ninth clock carries the ACK.
- START in any state (including repeated START) clears the bit counter and enters ADDR. STOP in any state enters IDLE, busy=0, sda_oe=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - [7:1]==SLAVE_ADDR: drive ACK, busy=1, go to PTR if [0]=0 or RDATA if [0]=1. On a read, temp_data is latched into a 16-bit shadow in the same cycle, so both bytes are coherent.
    - Mismatch: go to IGNORE and never drive.
  - PTR: shift 8 bits, store them in pointer, ACK, go to WDATA. Only pointer[1:0] selects the register; upper bits are stored but ignored.
  - WDATA:
    - Pointer 1 or 2, first data byte: update the register after the 8th bit, pulse wr_strobe, ACK.
    - Pointer 0 or 3 (read-only), or any later data byte: NACK with no update.
    - Stay in WDATA until STOP or START.
  - RDATA: drive a byte MSB first.
    - Source, 16 bits: reg0 = shadow; reg1 = {config_reg,8'h00}; reg2 = {general_reg,8'h00}; reg3 = DEFAULT_VAL.
    - Byte 0 = [15:8], byte 1 = [7:0], any further byte = 8'h00.
    - A bit value of 1 means release; 0 means drive low.
    - Release SDA on the fall after bit 0, then sample the master ACK on the 9th rise.
    - ACK (SDA=0) continues with the next byte. NACK goes to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- ACK timing: drive low from the SCL fall after bit 0 until the next SCL fall (the end of the 9th clock).
- The pointer persists across transactions until the next write, so "write pointer, STOP, read" works.
- Simultaneous START/STOP detection with a bit edge: START/STOP wins.

Decomposition:
- Shared package i2c_pkg:
  - state enum tgt_state_t (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE).
  - Register index constants REG_TEMP=2'b00, REG_CFG=2'b01, REG_GEN=2'b10, REG_DEF=2'b11.
  - DEFAULT_VAL default.
- One sub-module: i2c_bus_sync, containing the 2-FF synchronizers and outputs scl_rise, scl_fall, sda_s, start_det, stop_det.

Test Plan:
- Write 0x48+W, ptr 0x01, data 0xA5 -> three ACKs; config_reg=0xA5 after byte 3; one wr_strobe pulse.
- Write ptr 0x00, STOP, then read 0x48+R with temp_data=16'h1234 (master ACK, then NACK) -> bytes 0x12, 0x34; temp_data changed mid-read still returns 0x1234.
- Write ptr 0x03, repeated START, read 2 bytes -> 0x98, 0x21; no wr_strobe.
- Address 0x49 -> SDA never driven (sda_oe=0 whole frame), busy=0; next frame to 0x48 is ACKed normally.
- Write ptr 0x00, data 0x55 -> data NACKed, no register change; write ptr 0x02, data 0x3C, 0x77 -> first byte ACKed (general_reg=0x3C), second NACKed.
- rst_n low for one clk during the RDATA bit 3 low phase -> sda_oe=0 next edge, all outputs at reset values; next START proceeds normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } tgt_state_t;

  localparam logic [1:0]  REG_TEMP    = 2'b00;
  localparam logic [1:0]  REG_CFG     = 2'b01;
  localparam logic [1:0]  REG_GEN     = 2'b10;
  localparam logic [1:0]  REG_DEF     = 2'b11;
  localparam logic [15:0] DEFAULT_VAL = 16'h9821;

  // Byte 0 is the high byte, byte 1 the low byte, anything later reads as zero.
  function automatic logic [7:0] sel_byte(input logic [15:0] src, input logic [1:0] idx);
    case (idx)
      2'd0:    return src[15:8];
      2'd1:    return src[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge, START and STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff, sda_ff;
  logic       scl_d, sda_d;
  logic       scl_s;

  // Flops reset to the idle-bus level so leaving reset creates no false edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl_i};
      sda_ff <= {sda_ff[0], sda_i};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with pointer register and a 4-entry register file (temp/cfg/gen/default).
//
// state     | meaning
// IDLE      | waiting for START
// ADDR      | shifting in address byte
// ADDR_ACK  | ACK clock after address match
// PTR       | shifting in pointer byte
// PTR_ACK   | ACK clock after pointer
// WDATA     | shifting in write data bytes
// WDATA_ACK | ACK/NACK clock after a data byte
// RDATA     | driving a read byte MSB first
// RDATA_ACK | SDA released, sampling master ACK
// IGNORE    | not addressed or master NACKed; wait for START/STOP
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
  parameter logic [15:0] DEFAULT_VAL = i2c_pkg::DEFAULT_VAL,
  parameter logic [7:0]  CFG_RST     = 8'h00,
  parameter logic [7:0]  GEN_RST     = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] temp_data,
  output logic [7:0]  config_reg,
  output logic [7:0]  general_reg,
  output logic        wr_strobe,
  output logic        busy
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  tgt_state_t  state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [6:0]  shift, shift_n;
  logic [7:0]  pointer, pointer_n;
  logic [15:0] shadow, shadow_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic        ack_val, ack_val_n;
  logic        ack_phase, ack_phase_n;
  logic        rd, rd_n;
  logic        wr_first, wr_first_n;
  logic        sda_oe_n, busy_n, wr_strobe_n;
  logic [7:0]  config_n, general_n;

  logic [7:0]  rx_byte;
  logic [15:0] tx_src;
  logic [7:0]  tx_byte, tx_first, tx_next;
  logic [1:0]  nxt_idx;
  logic        unused_ptr_hi;

  assign rx_byte       = {shift, sda_s};
  assign nxt_idx       = (byte_idx == 2'd2) ? 2'd2 : byte_idx + 2'd1;
  assign tx_byte       = sel_byte(tx_src, byte_idx);
  assign tx_first      = sel_byte(tx_src, 2'd0);
  assign tx_next       = sel_byte(tx_src, nxt_idx);
  assign unused_ptr_hi = ^pointer[7:2];

  always_comb begin
    tx_src = DEFAULT_VAL;
    case (pointer[1:0])
      REG_TEMP: tx_src = shadow;
      REG_CFG:  tx_src = {config_reg, 8'h00};
      REG_GEN:  tx_src = {general_reg, 8'h00};
      REG_DEF:  tx_src = DEFAULT_VAL;
      default:  tx_src = DEFAULT_VAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= 3'd7;
      shift       <= '0;
      pointer     <= 8'h00;
      shadow      <= '0;
      byte_idx    <= '0;
      ack_val     <= 1'b0;
      ack_phase   <= 1'b0;
      rd          <= 1'b0;
      wr_first    <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      wr_strobe   <= 1'b0;
      config_reg  <= CFG_RST;
      general_reg <= GEN_RST;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      pointer     <= pointer_n;
      shadow      <= shadow_n;
      byte_idx    <= byte_idx_n;
      ack_val     <= ack_val_n;
      ack_phase   <= ack_phase_n;
      rd          <= rd_n;
      wr_first    <= wr_first_n;
      sda_oe      <= sda_oe_n;
      busy        <= busy_n;
      wr_strobe   <= wr_strobe_n;
      config_reg  <= config_n;
      general_reg <= general_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    pointer_n   = pointer;
    shadow_n    = shadow;
    byte_idx_n  = byte_idx;
    ack_val_n   = ack_val;
    ack_phase_n = ack_phase;
    rd_n        = rd;
    wr_first_n  = wr_first;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    wr_strobe_n = 1'b0;
    config_n    = config_reg;
    general_n   = general_reg;

    if (stop_det) begin
      state_n  = IDLE;
      busy_n   = 1'b0;
      sda_oe_n = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd7;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_n = rx_byte[6:0];
            if (bit_cnt != 3'd0) begin
              bit_cnt_n = bit_cnt - 3'd1;
            end else begin
              ack_phase_n = 1'b0;
              ack_val_n   = 1'b1;
              if (state == ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_n = ADDR_ACK;
                  busy_n  = 1'b1;
                  rd_n    = rx_byte[0];
                  if (rx_byte[0]) shadow_n = temp_data;
                end else begin
                  state_n = IGNORE;
                  busy_n  = 1'b0;
                end
              end else if (state == PTR) begin
                state_n   = PTR_ACK;
                pointer_n = rx_byte;
              end else begin
                state_n    = WDATA_ACK;
                wr_first_n = 1'b0;
                ack_val_n  = 1'b0;
                if (wr_first && (pointer[1:0] == REG_CFG || pointer[1:0] == REG_GEN)) begin
                  ack_val_n   = 1'b1;
                  wr_strobe_n = 1'b1;
                  if (pointer[1:0] == REG_CFG) config_n = rx_byte;
                  else general_n = rx_byte;
                end
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) sda_oe_n = ~tx_byte[bit_cnt];
          if (scl_rise) begin
            if (bit_cnt != 3'd0) begin
              bit_cnt_n = bit_cnt - 3'd1;
            end else begin
              state_n     = RDATA_ACK;
              ack_val_n   = 1'b0;
              ack_phase_n = 1'b0;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA_ACK: begin
          if (state == RDATA_ACK && ack_phase && scl_rise && sda_s) begin
            state_n = IGNORE;
          end else if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe_n    = ack_val;
              ack_phase_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd7;
              case (state)
                ADDR_ACK: begin
                  if (rd) begin
                    state_n    = RDATA;
                    byte_idx_n = 2'd0;
                    sda_oe_n   = ~tx_first[7];
                  end else begin
                    state_n = PTR;
                  end
                end
                PTR_ACK: begin
                  state_n    = WDATA;
                  wr_first_n = 1'b1;
                end
                RDATA_ACK: begin
                  state_n    = RDATA;
                  byte_idx_n = nxt_idx;
                  sda_oe_n   = ~tx_next[7];
                end
                default: state_n = WDATA;
              endcase
            end
          end
        end
        IDLE, IGNORE: ;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master against a register-file reference model.
module tb_i2c_reg_target;

  localparam int Q = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] temp_data = 16'h0000;
  logic        sda_oe, wr_strobe, busy;
  logic [7:0]  config_reg, general_reg;
  logic        sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_reg_target #(
    .SLAVE_ADDR (7'h48),
    .DEFAULT_VAL(16'h9821),
    .CFG_RST    (8'h00),
    .GEN_RST    (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .temp_data  (temp_data),
    .config_reg (config_reg),
    .general_reg(general_reg),
    .wr_strobe  (wr_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int strobe_pulses = 0;
  int strobe_cycles = 0;
  bit strobe_q = 1'b0;
  bit oe_seen = 1'b0;

  always @(negedge clk) begin
    if (wr_strobe) strobe_cycles++;
    if (wr_strobe && !strobe_q) strobe_pulses++;
    strobe_q = wr_strobe;
    if (sda_oe) oe_seen = 1'b1;
  end

  // Reference model of the target's architectural state
  logic [7:0]  m_cfg = 8'h00, m_gen = 8'h00, m_ptr = 8'h00;
  logic [15:0] m_shadow = 16'h0000;

  function automatic logic [7:0] exp_byte(input logic [7:0] ptr, input int idx);
    int src;
    case (ptr % 4)
      0: src = m_shadow;
      1: src = m_cfg * 256;
      2: src = m_gen * 256;
      default: src = 16'h9821;
    endcase
    if (idx == 0) return 8'(src / 256);
    if (idx == 1) return 8'(src % 256);
    return 8'h00;
  endfunction

  task automatic wait_q(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q(2);
    sda_m = 1'b0; wait_q(2);
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q(2);
    sda_m = 1'b1; wait_q(2);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q();
    r = sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, r);
    acked = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(~mack, r);
  endtask

  task automatic set_ptr(input logic [7:0] p, output logic acked);
    logic a0, a1;
    i2c_start(); write_byte(8'h90, a0); write_byte(p, a1); i2c_stop();
    m_ptr = p;
    acked = a0 & a1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL rst_wr_strobe got=%b exp=0", wr_strobe); end
    checks++; if (config_reg !== 8'h00) begin failures++; $display("FAIL rst_config got=%h exp=00", config_reg); end
    checks++; if (general_reg !== 8'h00) begin failures++; $display("FAIL rst_general got=%h exp=00", general_reg); end
  endtask

  task automatic test_write_cfg();
    logic a0, a1, a2;
    logic [7:0] d;
    int p0;
    for (int rep = 0; rep < 3; rep++) begin
      d = (rep == 0) ? 8'hA5 : 8'($urandom);
      p0 = strobe_pulses;
      i2c_start(); write_byte(8'h90, a0); write_byte(8'h01, a1);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy); end
      write_byte(d, a2);
      m_cfg = d; m_ptr = 8'h01;
      checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL wr_acks got=%b exp=111", {a0, a1, a2}); end
      checks++; if (config_reg !== m_cfg) begin failures++; $display("FAIL wr_config got=%h exp=%h", config_reg, m_cfg); end
      i2c_stop();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_stop got=%b exp=0", busy); end
      checks++;
      if (strobe_pulses - p0 != 1 || strobe_cycles != strobe_pulses) begin
        failures++; $display("FAIL wr_strobe got=%0d pulses/%0d cycles exp=1 new single-cycle pulse", strobe_pulses - p0, strobe_cycles);
      end
    end
  endtask

  task automatic test_read_temp();
    logic a, pa;
    logic [7:0] b0, b1;
    logic [15:0] t;
    for (int rep = 0; rep < 2; rep++) begin
      t = (rep == 0) ? 16'h1234 : 16'($urandom);
      set_ptr(8'h00, pa);
      temp_data = t;
      i2c_start(); write_byte(8'h91, a);
      m_shadow = t;
      read_byte(1'b1, b0);
      temp_data = 16'($urandom);
      read_byte(1'b0, b1);
      i2c_stop();
      checks++; if ((pa & a) !== 1'b1) begin failures++; $display("FAIL rt_acks got=%b exp=1", pa & a); end
      checks++; if (b0 !== exp_byte(m_ptr, 0)) begin failures++; $display("FAIL rt_byte0 got=%h exp=%h", b0, exp_byte(m_ptr, 0)); end
      checks++; if (b1 !== exp_byte(m_ptr, 1)) begin failures++; $display("FAIL rt_byte1 got=%h exp=%h", b1, exp_byte(m_ptr, 1)); end
    end
  endtask

  task automatic test_read_default();
    logic a0, a1, a2;
    logic [7:0] b0, b1, b2;
    int p0;
    p0 = strobe_pulses;
    i2c_start(); write_byte(8'h90, a0); write_byte(8'h03, a1);
    m_ptr = 8'h03;
    i2c_start(); write_byte(8'h91, a2);
    read_byte(1'b1, b0); read_byte(1'b0, b1);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL rd_def_acks got=%b exp=111", {a0, a1, a2}); end
    checks++; if ({b0, b1} !== {exp_byte(m_ptr, 0), exp_byte(m_ptr, 1)}) begin
      failures++; $display("FAIL rd_def_data got=%h%h exp=%h%h", b0, b1, exp_byte(m_ptr, 0), exp_byte(m_ptr, 1));
    end
    checks++; if (strobe_pulses != p0) begin failures++; $display("FAIL rd_def_strobe got=%0d exp=0", strobe_pulses - p0); end
    // Config register read with a third byte past the 16-bit source
    i2c_start(); write_byte(8'h90, a0); write_byte(8'h01, a1);
    m_ptr = 8'h01;
    i2c_start(); write_byte(8'h91, a2);
    read_byte(1'b1, b0); read_byte(1'b1, b1); read_byte(1'b0, b2);
    i2c_stop();
    checks++; if ({b0, b1, b2} !== {exp_byte(m_ptr, 0), exp_byte(m_ptr, 1), exp_byte(m_ptr, 2)}) begin
      failures++; $display("FAIL rd_cfg_data got=%h%h%h exp=%h%h%h", b0, b1, b2, exp_byte(m_ptr, 0), exp_byte(m_ptr, 1), exp_byte(m_ptr, 2));
    end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    logic busy_seen;
    oe_seen = 1'b0;
    i2c_start(); write_byte(8'h92, a0);
    busy_seen = busy;
    write_byte(8'($urandom), a1);
    i2c_stop();
    checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL mm_sda_driven got=%b exp=0", oe_seen); end
    checks++; if ({a0, busy_seen} !== 2'b00) begin failures++; $display("FAIL mm_ack_busy got=%b exp=00", {a0, busy_seen}); end
    d = 8'($urandom);
    i2c_start(); write_byte(8'h90, a0); write_byte(8'hFE, a2); write_byte(d, a3); i2c_stop();
    m_ptr = 8'hFE; m_gen = d;
    checks++; if ({a0, a2, a3} !== 3'b111) begin failures++; $display("FAIL mm_next_acks got=%b exp=111", {a0, a2, a3}); end
    checks++; if (general_reg !== m_gen) begin failures++; $display("FAIL mm_next_general got=%h exp=%h", general_reg, m_gen); end
  endtask

  task automatic test_write_nack();
    logic a0, a1, a2, a3;
    int p0;
    p0 = strobe_pulses;
    i2c_start(); write_byte(8'h90, a0); write_byte(8'h00, a1); write_byte(8'h55, a2); i2c_stop();
    m_ptr = 8'h00;
    checks++; if ({a0, a1, a2} !== 3'b110) begin failures++; $display("FAIL ro_acks got=%b exp=110", {a0, a1, a2}); end
    checks++; if ({config_reg, general_reg} !== {m_cfg, m_gen} || strobe_pulses != p0) begin
      failures++; $display("FAIL ro_nochange got=%h%h/%0d exp=%h%h/0", config_reg, general_reg, strobe_pulses - p0, m_cfg, m_gen);
    end
    i2c_start(); write_byte(8'h90, a0); write_byte(8'h02, a1); write_byte(8'h3C, a2); write_byte(8'h77, a3); i2c_stop();
    m_ptr = 8'h02; m_gen = 8'h3C;
    checks++; if ({a0, a1, a2, a3} !== 4'b1110) begin failures++; $display("FAIL gen2_acks got=%b exp=1110", {a0, a1, a2, a3}); end
    checks++; if (general_reg !== m_gen) begin failures++; $display("FAIL gen2_general got=%h exp=%h", general_reg, m_gen); end
    checks++; if (strobe_pulses - p0 != 1) begin failures++; $display("FAIL gen2_strobe got=%0d exp=1", strobe_pulses - p0); end
  endtask

  task automatic test_reset_mid_read();
    logic a, pa, r;
    logic [7:0] d, b0, b1;
    int n;
    set_ptr(8'h00, pa);
    temp_data = 16'h1234;
    i2c_start(); write_byte(8'h91, a);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
    // Bit 3 of 0x12 is 0, so the target should be pulling SDA low here
    sda_m = 1'b1;
    n = 0;
    while (sda_oe !== 1'b1 && n < 4 * Q) begin
      @(negedge clk); n++;
    end
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL mr_driving got=%b exp=1", sda_oe); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_cfg = 8'h00; m_gen = 8'h00; m_ptr = 8'h00;
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL mr_sda_oe got=%b exp=0", sda_oe); end
    checks++; if ({busy, wr_strobe, config_reg, general_reg} !== {2'b00, m_cfg, m_gen}) begin
      failures++; $display("FAIL mr_outputs got=%b%b/%h/%h exp=00/%h/%h", busy, wr_strobe, config_reg, general_reg, m_cfg, m_gen);
    end
    wait_q();
    scl_m = 1'b1; wait_q(2);
    scl_m = 1'b0; wait_q();
    i2c_stop();
    d = 8'($urandom);
    i2c_start(); write_byte(8'h90, a); write_byte(8'h01, pa); write_byte(d, r); i2c_stop();
    m_cfg = d; m_ptr = 8'h01;
    checks++; if ({a, pa, r} !== 3'b111) begin failures++; $display("FAIL mr_after_acks got=%b exp=111", {a, pa, r}); end
    i2c_start(); write_byte(8'h91, a); read_byte(1'b1, b0); read_byte(1'b0, b1); i2c_stop();
    checks++; if ({b0, b1} !== {exp_byte(m_ptr, 0), exp_byte(m_ptr, 1)}) begin
      failures++; $display("FAIL mr_after_read got=%h%h exp=%h%h", b0, b1, exp_byte(m_ptr, 0), exp_byte(m_ptr, 1));
    end
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_write_cfg();
    test_read_temp();
    test_read_default();
    test_addr_mismatch();
    test_write_nack();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
